// File: rtl/regfile_32x32.sv
// 32 x 32-bit register file: two clocked read ports with write-to-read bypass, one write port, r0 hardwired to zero.
// Reads and writes take effect on the same rising edge (1-cycle latency); hold freezes only the operand flops.
module regfile_32x32 #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] rs_addr,
  input  logic [DEPTH_LOG2-1:0] rt_addr,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic [WIDTH-1:0]      rd_data,
  input  logic                  hold,
  output logic [WIDTH-1:0]      rs_data,
  output logic [WIDTH-1:0]      rt_data
);

  localparam int NREG = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_en;
  logic [WIDTH-1:0] rs_next;
  logic [WIDTH-1:0] rt_next;

  // Address 0 is excluded here, so neither storage nor bypass ever sees it.
  assign wr_en = we && (rd_addr != '0);

  always_comb begin
    rs_next = '0;
    rt_next = '0;
    if (rs_addr != '0) begin
      rs_next = (wr_en && (rd_addr == rs_addr)) ? rd_data : regs[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_next = (wr_en && (rd_addr == rt_addr)) ? rd_data : regs[rt_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      rs_data <= '0;
      rt_data <= '0;
    end else begin
      if (wr_en) begin
        regs[rd_addr] <= rd_data;
      end
      if (!hold) begin
        rs_data <= rs_next;
        rt_data <= rt_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32: reference model of the register contents checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic        hold = 1'b0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_reg [32];
  logic [31:0] m_rs = '0;
  logic [31:0] m_rt = '0;

  regfile_32x32 #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .we      (we),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .hold    (hold),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
  end

  // Model: commit the write first, then an un-held read returns the newest contents; r0 is always 0.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_rs = '0;
      m_rt = '0;
    end else begin
      if (we && rd_addr != 0) m_reg[rd_addr] = rd_data;
      if (!hold) begin
        m_rs = (rs_addr == 0) ? 32'h0 : m_reg[rs_addr];
        m_rt = (rt_addr == 0) ? 32'h0 : m_reg[rt_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rs", rs_data, m_rs);
      check("model_rt", rt_data, m_rt);
    end
  end

  task automatic step(input logic rst, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                      input logic h);
    reset   = rst;
    we      = w;
    rd_addr = wa;
    rd_data = wd;
    rs_addr = ra;
    rt_addr = rb;
    hold    = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_v;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_rs", rs_data, 32'h0);
    check("reset_rt", rt_data, 32'h0);
    chk_en = 1'b1;

    // Reset clear: reset beats a simultaneous write
    step(0, 1, 5, 32'hFFFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 0, 5, 5, 0);
    check("r5_written", rs_data, 32'hFFFF_FFFF);
    step(1, 1, 5, 32'h1234_5678, 5, 5, 0);
    check("rst_edge_rs", rs_data, 32'h0);
    check("rst_edge_rt", rt_data, 32'h0);
    step(0, 0, 0, 0, 5, 5, 0);
    check("r5_after_rst", rs_data, 32'h0);

    // Write then read
    step(0, 1, 3, 32'h0F80_0000, 0, 0, 0);
    step(0, 1, 4, 32'hFFFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 0, 3, 4, 0);
    check("wr_rd_rs", rs_data, 32'h0F80_0000);
    check("wr_rd_rt", rt_data, 32'hFFFF_FFFF);
    check("and_result", rs_data & rt_data, 32'h0F80_0000);

    // Zero register
    step(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
    check("zero_same", rs_data, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("zero_next", rs_data, 32'h0);

    // Bypass
    step(0, 1, 7, 32'h0000_0001, 0, 0, 0);
    step(0, 1, 7, 32'hA5A5_A5A5, 7, 7, 0);
    check("bypass_rs", rs_data, 32'hA5A5_A5A5);
    check("bypass_rt", rt_data, 32'hA5A5_A5A5);

    // Hold
    step(0, 1, 7, 32'h0000_0001, 7, 3, 0);
    check("hold_pre", rs_data, 32'h0000_0001);
    step(0, 1, 7, 32'h5555_5555, 3, 4, 1);
    check("hold_c1", rs_data, 32'h0000_0001);
    step(0, 0, 0, 0, 4, 0, 1);
    check("hold_c2", rs_data, 32'h0000_0001);
    step(0, 0, 0, 0, 0, 7, 1);
    check("hold_c3", rs_data, 32'h0000_0001);
    check("hold_rt", rt_data, 32'h0F80_0000);
    step(0, 0, 0, 0, 7, 0, 0);
    check("hold_release", rs_data, 32'h5555_5555);

    // Sweep
    for (int i = 1; i < 32; i++) step(0, 1, 5'(i), 32'(i) * 32'h0101_0101, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 5'(i), 5'(31 - i), 0);
      exp_v = 32'(i) * 32'h0101_0101;
      check("sweep_rs", rs_data, exp_v);
      exp_v = 32'(31 - i) * 32'h0101_0101;
      check("sweep_rt", rt_data, exp_v);
    end

    // Hold is ignored while reset is asserted
    step(0, 0, 0, 0, 31, 30, 0);
    step(1, 1, 9, 32'h7777_7777, 31, 30, 1);
    check("rst_hold_rs", rs_data, 32'h0);
    check("rst_hold_rt", rt_data, 32'h0);
    step(0, 0, 0, 0, 31, 9, 0);
    check("post_rst_r31", rs_data, 32'h0);
    check("post_rst_r9", rt_data, 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_32x32.md
# regfile_32x32

Synchronous-read 32 × 32-bit register file that supplies the `rs`/`rt` operands to the 32-bit ALU slices (`and_32bit` and its siblings) and accepts the ALU result `rd` for write-back. Reads and writes are both clocked. A same-cycle write-to-read bypass guarantees that an operand read never returns stale data. A `hold` input freezes the operand outputs during a pipeline stall.

## Interface

Parameters:
- `WIDTH`, 32: data width of every register and port.
- `DEPTH_LOG2`, 5: address width. The register count is 2^`DEPTH_LOG2` = 32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `rs_addr`  in  5  read address, port A.
- `rt_addr`  in  5  read address, port B.
- `we`  in  1  write enable.
- `rd_addr`  in  5  write address.
- `rd_data`  in  32  write data (ALU result).
- `hold`  in  1  when 1, `rs_data`/`rt_data` keep their current value.
- `rs_data`  out  32  registered operand A (drives ALU `rs`).
- `rt_data`  out  32  registered operand B (drives ALU `rt`).

## Operation

- Storage is 32 registers, `r0`–`r31`.
  - `r0` reads as 0 at all times.
  - Writes to address 0 are discarded.
- Write: on each rising edge with `reset`=0, `we`=1 and `rd_addr`≠0, `r[rd_addr]` ← `rd_data`.
- Read: on each rising edge with `reset`=0 and `hold`=0:
  - `rs_data` ← value of `r[rs_addr]`.
  - `rt_data` ← value of `r[rt_addr]`.
- Bypass: if `we`=1, `rd_addr`≠0 and `rd_addr`==`rs_addr`, then `rs_data` ← `rd_data`, not the old contents. The same rule applies independently to `rt`.
- Address 0 reads return 0 even when `we`=1 and `rd_addr`=0 in the same cycle. No bypass ever occurs on address 0.
- `hold`=1 blocks only the output registers. Writes still commit, so a later un-held read sees the new value.
- `rs_addr`==`rt_addr` is legal; both outputs carry the same value.
- Data is passed unmodified: no sign or zero extension, no width change.

## Timing

- Reset: on the rising edge where `reset`=1:
  - `r1`–`r31` are cleared to 0.
  - `rs_data` and `rt_data` are cleared to 0.
  - A `we` pulse in the same cycle is ignored; reset has priority over write.
  - `hold` is ignored during reset.
- Reset asserted mid-operation discards any write presented in that cycle. The first normal cycle after reset deasserts reads all-zero contents.
- Read latency is 1 cycle: an address presented before edge N appears on `rs_data`/`rt_data` after edge N.
- Write latency is 1 cycle. Through the bypass, a read of the same address in the write cycle returns the new data after the same edge.
- No combinational path exists from any input to `rs_data`/`rt_data`; the outputs are pure flops.
- No handshake and no back-pressure exist beyond `hold`. Every cycle with `we`=1 commits a write.

## Test plan

- Reset clear:
  - Stimulus: write `r5`=32'hFFFF_FFFF, then assert `reset` for 1 cycle together with `we`=1, `rd_addr`=5, `rd_data`=32'h1234_5678.
  - Required: read `r5` → 0; `rs_data`/`rt_data` = 0 immediately after the reset edge.
- Write then read:
  - Stimulus: write `r3`=32'h0F80_0000, `r4`=32'hFFFF_FFFF. Next cycle, set `rs_addr`=3, `rt_addr`=4.
  - Required: after the edge, `rs_data`=32'h0F80_0000 and `rt_data`=32'hFFFF_FFFF. Feeding these to `and_32bit` yields 32'h0F80_0000.
- Zero register:
  - Stimulus: `we`=1, `rd_addr`=0, `rd_data`=32'hDEAD_BEEF, with `rs_addr`=0 in the same and the next cycle.
  - Required: `rs_data`=0 both cycles.
- Bypass:
  - Stimulus: `r7` holds 32'h0000_0001. In one cycle: `we`=1, `rd_addr`=7, `rd_data`=32'hA5A5_A5A5, `rs_addr`=7, `rt_addr`=7.
  - Required: both outputs = 32'hA5A5_A5A5 after that edge.
- Hold:
  - Stimulus: `rs_data` currently 32'h0000_0001 from `r7`. Assert `hold`=1 for 3 cycles while writing `r7`=32'h5555_5555 and changing `rs_addr`.
  - Required: `rs_data` stays 32'h0000_0001 through the hold. After `hold`=0 with `rs_addr`=7, `rs_data`=32'h5555_5555.
- Sweep:
  - Stimulus: write `r[i]`=i×32'h0101_0101 for i=1..31, then read all pairs (i, 31−i).
  - Required: every output matches its stored value; address 0 reads 0.
